// File: rtl/gb_interrupt_ctrl_if.sv
// Bus, request and dispatch-handshake signals between the CPU core and gb_interrupt_ctrl.
// The master modport is the CPU side; the slave modport is the interrupt controller.
interface gb_interrupt_ctrl_if;
    logic [4:0]  irq_req;
    logic [15:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        irq_pending;
    // Dispatch handshake: irq_ack and irq_vec_req are single-cycle pulses from the CPU;
    // irq_vec_valid is a single-cycle strobe, one cycle after an accepted irq_vec_req,
    // qualifying irq_vector. There is no backpressure; strobes outside their state are dropped.
    logic        irq_ack;
    logic        irq_vec_req;
    logic [7:0]  irq_vector;
    logic        irq_vec_valid;
    logic [1:0]  dbg_state;

    modport master (
        output irq_req, addr, wr_en, rd_en, wdata, irq_ack, irq_vec_req,
        input  rdata, irq_pending, irq_vector, irq_vec_valid, dbg_state
    );

    modport slave (
        input  irq_req, addr, wr_en, rd_en, wdata, irq_ack, irq_vec_req,
        output rdata, irq_pending, irq_vector, irq_vec_valid, dbg_state
    );
endinterface

// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, pending/wake output and vector dispatch FSM.
// Define GB_IRQ_LATE_CANCEL_EN to resolve the vector at irq_vec_req (DMG-accurate late cancel).
module gb_interrupt_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    gb_interrupt_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACKED  = 2'd1,
        ST_VECTOR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  vector_q, vector_d;
    logic [4:0]  pend;
    logic [4:0]  win;
    logic [4:0]  clr;
    logic [7:0]  win_vec;
`ifndef GB_IRQ_LATE_CANCEL_EN
    logic [7:0]  lat_q, lat_d;
`endif

    // Isolate the lowest set bit of the pending mask; it is the winner.
    always_comb begin
        pend = ie_q[4:0] & if_q;
        win  = pend & (~pend + 5'd1);
        case (win)
            5'b00001: win_vec = 8'h40;
            5'b00010: win_vec = 8'h48;
            5'b00100: win_vec = 8'h50;
            5'b01000: win_vec = 8'h58;
            5'b10000: win_vec = 8'h60;
            default:  win_vec = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        clr      = 5'b0;
`ifndef GB_IRQ_LATE_CANCEL_EN
        lat_d    = lat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.irq_ack) begin
                    state_d = ST_ACKED;
`ifndef GB_IRQ_LATE_CANCEL_EN
                    lat_d = win_vec;
                    clr   = win;
`endif
                end
            end
            ST_ACKED: begin
                if (bus.irq_vec_req) begin
                    state_d = ST_VECTOR;
`ifdef GB_IRQ_LATE_CANCEL_EN
                    vector_d = win_vec;
                    clr      = win;
`else
                    vector_d = lat_q;
`endif
                end
            end
            ST_VECTOR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Write, then dispatch clear, then requests: a request always survives.
    always_comb begin
        if_d = if_q;
        ie_d = ie_q;
        if (bus.wr_en && bus.addr == 16'hFF0F) if_d = bus.wdata[4:0];
        if (bus.wr_en && bus.addr == 16'hFFFF) ie_d = bus.wdata;
        if_d = (if_d & ~clr) | bus.irq_req;

        rdata_d = rdata_q;
        if (bus.rd_en) begin
            case (bus.addr)
                16'hFF0F: rdata_d = {3'b111, if_q};
                16'hFFFF: rdata_d = ie_q;
                default:  rdata_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            if_q     <= 5'b0;
            ie_q     <= 8'h00;
            rdata_q  <= 8'h00;
            vector_q <= 8'h00;
`ifndef GB_IRQ_LATE_CANCEL_EN
            lat_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            if_q     <= if_d;
            ie_q     <= ie_d;
            rdata_q  <= rdata_d;
            vector_q <= vector_d;
`ifndef GB_IRQ_LATE_CANCEL_EN
            lat_q    <= lat_d;
`endif
        end
    end

    assign bus.rdata         = rdata_q;
    assign bus.irq_pending   = |pend;
    assign bus.irq_vector    = vector_q;
    assign bus.irq_vec_valid = (state_q == ST_VECTOR);
    assign bus.dbg_state     = state_q;
endmodule

// File: doc/gb_interrupt_ctrl.md
# gb_interrupt_ctrl

Game Boy interrupt controller that sits directly upstream of the CPU core's register file and dispatch microcode. It holds the IF (0xFF0F) and IE (0xFFFF) registers, collects request pulses from VBlank, STAT, Timer, Serial and Joypad, and drives the pending/wake signal the CPU samples alongside its IME bit. During interrupt dispatch it runs a short handshake with the CPU and supplies the restart vector that the CPU loads into `pch`/`pcl`.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `irq_req` in 5: one-cycle request pulses. Bit 0 = VBlank, bit 1 = STAT, bit 2 = Timer, bit 3 = Serial, bit 4 = Joypad.
- `addr` in 16: CPU bus address.
- `wr_en` in 1: bus write strobe.
- `rd_en` in 1: bus read strobe.
- `wdata` in 8: bus write data.
- `rdata` out 8: registered read data.
- `irq_pending` out 1: `|(IE[4:0] & IF[4:0])`. Combinational from registers, independent of IME. The CPU uses it for dispatch gating and for HALT wake.
- `irq_ack` in 1: one-cycle pulse from the CPU that starts dispatch.
- `irq_vec_req` in 1: one-cycle pulse from the CPU requesting the vector, issued after the PCH push.
- `irq_vector` out 8: low byte of the restart address. The high byte is always 0x00.
- `irq_vec_valid` out 1: one-cycle strobe qualifying `irq_vector`.

## Operation
- **IF register**: 5 bits. Reads return `{3'b111, IF}`.
- **IE register**: all 8 bits are stored. Reads return all 8 bits. Only bits [4:0] participate in pending logic.
- **Register write order within a cycle**:
  - Start from the current value.
  - A bus write replaces it.
  - The dispatch clear then clears its selected bit.
  - `irq_req` bits are then ORed in.
  - Net effect: a request wins over both a write and a clear in the same cycle.
- **Reads**: `rd_en` at 0xFF0F or 0xFFFF loads `rdata` on the next edge. Any other address loads 0xFF. When `rd_en` is low, `rdata` holds its value.
- **Priority**: lowest set bit of `IE & IF` wins.
- **Vector encoding**: bit *n* maps to 0x40 + 8n, giving 0x40/0x48/0x50/0x58/0x60. No bit set gives 0x00 (cancelled dispatch).
- **State machine**:
  - IDLE:
    - `irq_ack` moves to ACKED.
    - `irq_vec_req` is ignored.
  - ACKED:
    - `irq_vec_req` resolves the vector from the register values held at that cycle, before that cycle's writes.
    - It clears the winning IF bit at the edge and moves to VECTOR.
    - `irq_ack` is ignored.
  - VECTOR:
    - `irq_vec_valid`=1 with `irq_vector` stable for one cycle.
    - Unconditional return to IDLE.
- **Reset** (any state, including mid-dispatch):
  - State returns to IDLE.
  - IF=0x00 (reads 0xE0), IE=0x00.
  - `rdata`=0x00, `irq_vector`=0x00, `irq_vec_valid`=0, `irq_pending`=0.

## Timing
- `irq_req` pulse at cycle N → IF bit visible at N+1; `irq_pending` high at N+1 if enabled.
- `irq_ack` at N → ACKED at N+1.
- `irq_vec_req` at M → `irq_vec_valid` and `irq_vector` at M+1. IF bit is clear from M+1.
- Bus read at N → `rdata` valid at N+1.
- `irq_vector` holds its last value outside the VECTOR cycle.
- A write to IE or IF during ACKED, at or before the `irq_vec_req` cycle's predecessor, affects vector selection.

## Configuration
- **`GB_IRQ_LATE_CANCEL_EN` defined** (DMG-accurate): behaviour exactly as above. The vector is resolved at `irq_vec_req`, so IE/IF changes during the push can retarget or cancel (0x00) the dispatch.
- **Macro undefined**:
  - Vector is resolved and latched at the `irq_ack` cycle.
  - The winning IF bit is cleared at the `irq_ack` edge.
  - `irq_vec_req` only releases the latched vector.
  - Cancellation never occurs, except that ack with nothing pending latches 0x00.
  - State timing is unchanged.

## Test plan
- **Reset values**: reset, then read 0xFF0F and 0xFFFF → `rdata` 0xE0 then 0x00; `irq_pending`=0.
- **Priority**: write IE=0x1F; pulse `irq_req`=0x14 → IF reads 0xF4 and `irq_pending`=1. Run ack, then vec_req → `irq_vector`=0x50, and IF reads 0xF0 afterwards.
- **Request vs. write collision**: write IF=0x00 in the same cycle as `irq_req`=0x01 → IF reads 0xE1.
- **Late cancel** (macro on): IE=0x01, IF=0x01. After ack, write IE=0x00, then vec_req → `irq_vector`=0x00 and IF remains 0xE1. With the macro off → 0x40 and IF 0xE0.
- **Ignored strobes**: `irq_vec_req` in IDLE → no `irq_vec_valid`. A second `irq_ack` in ACKED does not restart dispatch.
- **Reset mid-dispatch**: assert `reset_n`=0 in ACKED with IF=0x04 → next cycle IDLE, IF reads 0xE0, and a subsequent vec_req gives no valid strobe.
